// File: rtl/dds_phase_detector.sv
// -----------------------------------------------------------------------------
// dds_phase_detector
//
// Recovers the instantaneous phase (pword) and the phase step since the
// previous result (fword) from an offset-binary cos/sin sample pair. It is the
// inverse of a DDS: cos/sin in, phase/frequency words out. The core is an
// iterative vectoring-mode CORDIC behind a valid/ready input handshake.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-high reset
//   in_valid   : cos/sin sample presented
//   in_ready   : block can accept a sample (IDLE or DONE)
//   cos, sin   : offset-binary inputs, 2^(DATA_BITWIDTH-1) is zero
//   out_valid  : one-cycle pulse, pword/fword updated in this cycle
//   pword      : recovered phase, full turn = 2^DEPTH_BITWIDTH
//   fword      : pword minus previous pword, modulo 2^DEPTH_BITWIDTH
//
// A result appears ITERATIONS+2 cycles after the accept edge.
// -----------------------------------------------------------------------------
module dds_phase_detector #(
  parameter int DEPTH_BITWIDTH = 16,
  parameter int DATA_BITWIDTH  = 14,
  parameter int ITERATIONS     = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_BITWIDTH-1:0]  cos,
  input  logic [DATA_BITWIDTH-1:0]  sin,
  output logic                      out_valid,
  output logic [DEPTH_BITWIDTH-1:0] pword,
  output logic [DEPTH_BITWIDTH-1:0] fword
);

  localparam int D  = DEPTH_BITWIDTH;
  localparam int DW = DATA_BITWIDTH;
  // Two extra bits absorb the CORDIC gain (~1.647) on a full-scale vector.
  localparam int XW = DATA_BITWIDTH + 2;
  localparam int KW = $clog2(ITERATIONS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

  // atan(2^-k) as a fraction of a full turn, scaled by 2^32.
  function automatic logic [31:0] atan_turn32(input int k);
    case (k)
      0:  return 32'h2000_0000;
      1:  return 32'h12E4_051E;
      2:  return 32'h09FB_385B;
      3:  return 32'h0511_11D4;
      4:  return 32'h028B_0D43;
      5:  return 32'h0145_D7E1;
      6:  return 32'h00A2_F61E;
      7:  return 32'h0051_7C55;
      8:  return 32'h0028_BE53;
      9:  return 32'h0014_5F2F;
      10: return 32'h000A_2F98;
      11: return 32'h0005_17CC;
      12: return 32'h0002_8BE6;
      13: return 32'h0001_45F3;
      14: return 32'h0000_A2FA;
      15: return 32'h0000_517D;
      // Beyond k=15 atan(2^-k) halves per step to well below 1 LSB of 2^-32.
      default: return 32'h0000_517D >> (k - 15);
    endcase
  endfunction

  // A[k] = round(atan(2^-k) * 2^D / (2*pi)), rescaled from the 2^32 table.
  function automatic logic [D-1:0] atan_step(input int k);
    logic [63:0] t;
    t = ((({32'd0, atan_turn32(k)}) << D) + 64'h0000_0000_8000_0000) >> 32;
    return D'(t);
  endfunction

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   zero_q, zero_d;
  logic                   first_q, first_d;
  logic                   out_valid_q, out_valid_d;
  logic [D-1:0]           pword_q, pword_d;
  logic [D-1:0]           fword_q, fword_d;

  logic [DW-1:0]          cos_q, cos_d;
  logic [DW-1:0]          sin_q, sin_d;
  logic signed [XW-1:0]   x_q, x_d;
  logic signed [XW-1:0]   y_q, y_d;
  logic [D-1:0]           z_q, z_d;

  logic signed [DW-1:0]   cos_c, sin_c;
  logic signed [XW-1:0]   x0_c, y0_c;
  logic [D-1:0]           result_c;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign pword     = pword_q;
  assign fword     = fword_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    zero_d      = zero_q;
    first_d     = first_q;
    out_valid_d = 1'b0;
    pword_d     = pword_q;
    fword_d     = fword_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;

    // Offset-binary to two's complement is an MSB flip.
    cos_c    = {~cos_q[DW-1], cos_q[DW-2:0]};
    sin_c    = {~sin_q[DW-1], sin_q[DW-2:0]};
    x0_c     = {{2{cos_c[DW-1]}}, cos_c};
    y0_c     = {{2{sin_c[DW-1]}}, sin_c};
    result_c = zero_q ? '0 : z_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cos_d   = cos;
          sin_d   = sin;
          state_d = PRE;
        end
      end

      PRE: begin
        zero_d = (x0_c == '0) && (y0_c == '0);
        // Fold the left half-plane onto the right so the rotations converge.
        if (x0_c < 0) begin
          x_d = -x0_c;
          y_d = -y0_c;
          z_d = {1'b1, {(D-1){1'b0}}};
        end else begin
          x_d = x0_c;
          y_d = y0_c;
          z_d = '0;
        end
        k_d     = '0;
        state_d = ITER;
      end

      ITER: begin
        // Rotate toward y=0, accumulating the applied angle in z (wraps mod 2^D).
        if (!y_q[XW-1]) begin
          x_d = x_q + (y_q >>> k_q);
          y_d = y_q - (x_q >>> k_q);
          z_d = z_q + atan_step(int'(k_q));
        end else begin
          x_d = x_q - (y_q >>> k_q);
          y_d = y_q + (x_q >>> k_q);
          z_d = z_q - atan_step(int'(k_q));
        end
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) state_d = DONE;
      end

      DONE: begin
        pword_d     = result_c;
        fword_d     = first_q ? '0 : (result_c - pword_q);
        first_d     = 1'b0;
        out_valid_d = 1'b1;
        if (in_valid) begin
          cos_d   = cos;
          sin_d   = sin;
          state_d = PRE;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      zero_q      <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      pword_q     <= '0;
      fword_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      zero_q      <= zero_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      pword_q     <= pword_d;
      fword_q     <= fword_d;
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    cos_q <= cos_d;
    sin_q <= sin_d;
    x_q   <= x_d;
    y_q   <= y_d;
    z_q   <= z_d;
  end

endmodule

// File: tb/tb_dds_phase_detector.sv
module tb_dds_phase_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] cos_i = 14'd8192;
  logic [13:0] sin_i = 14'd8192;
  logic        out_valid;
  logic [15:0] pword;
  logic [15:0] fword;

  int checks = 0;
  int errors = 0;

  dds_phase_detector #(
    .DEPTH_BITWIDTH(16),
    .DATA_BITWIDTH (14),
    .ITERATIONS    (14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cos      (cos_i),
    .sin      (sin_i),
    .out_valid(out_valid),
    .pword    (pword),
    .fword    (fword)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Ideal DDS sample for a phase word, amplitude 6000 around mid-scale.
  function automatic logic [13:0] gen_cos(input int ph);
    real a;
    a = 2.0 * 3.14159265358979 * real'(ph) / 65536.0;
    return 14'(8192 + int'(6000.0 * $cos(a)));
  endfunction

  function automatic logic [13:0] gen_sin(input int ph);
    real a;
    a = 2.0 * 3.14159265358979 * real'(ph) / 65536.0;
    return 14'(8192 + int'(6000.0 * $sin(a)));
  endfunction

  // Present one sample, wait for accept, then wait for out_valid.
  // lat = edges from accept edge to the edge after which out_valid is seen.
  task automatic send_sample(input logic [13:0] c, input logic [13:0] s,
                             output int lat, output bit ok);
    int guard;
    ok  = 1'b0;
    lat = 0;
    @(negedge clk);
    cos_i    = c;
    sin_i    = s;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (pword !== 16'h0000) begin errors++; $display("FAIL reset_pword got %h want 0000", pword); end
    checks++;
    if (fword !== 16'h0000) begin errors++; $display("FAIL reset_fword got %h want 0000", fword); end
  endtask

  task automatic test_quadrants;
    logic [13:0] cv [4] = '{14'd12192, 14'd8192, 14'd4192, 14'd8192};
    logic [13:0] sv [4] = '{14'd8192, 14'd12192, 14'd8192, 14'd4192};
    logic [15:0] ev [4] = '{16'd0, 16'd16384, 16'd32768, 16'd49152};
    int lat;
    bit ok;
    logic signed [15:0] d;
    for (int q = 0; q < 4; q++) begin
      send_sample(cv[q], sv[q], lat, ok);
      checks++;
      if (!ok || lat != 16) begin
        errors++;
        $display("FAIL quad%0d_latency got %0d (seen %0d) want 16", q, lat, ok);
      end
      d = pword - ev[q];
      checks++;
      if (d > 8 || d < -8) begin
        errors++;
        $display("FAIL quad%0d_pword got %0d want %0d +-8", q, pword, ev[q]);
      end
      if (q == 0) begin
        checks++;
        if (fword !== 16'h0000) begin errors++; $display("FAIL quad0_first_fword got %h want 0000", fword); end
      end else begin
        d = fword - 16'd16384;
        checks++;
        if (d > 16 || d < -16) begin
          errors++;
          $display("FAIL quad%0d_fword got %0d want 16384 +-16", q, fword);
        end
      end
    end
  endtask

  task automatic test_zero;
    int lat;
    bit ok;
    logic signed [15:0] d;
    send_sample(14'd8192, 14'd8192, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_done got timeout want out_valid"); end
    checks++;
    if (pword !== 16'h0000) begin errors++; $display("FAIL zero_pword got %h want 0000", pword); end
    // Previous result was ~49152, so the step to 0 is ~16384.
    d = fword - 16'd16384;
    checks++;
    if (d > 8 || d < -8) begin errors++; $display("FAIL zero_fword got %0d want 16384 +-8", fword); end
  endtask

  task automatic test_dds_track;
    int fw [2] = '{32'h1000, 32'h0100};
    int lat;
    bit ok;
    int ph;
    logic [15:0] ef;
    logic signed [15:0] d;
    for (int f = 0; f < 2; f++) begin
      ef = 16'((16 * fw[f]) & 32'hFFFF);
      for (int i = 0; i < 5; i++) begin
        ph = (i * 16 * fw[f]) & 32'hFFFF;
        send_sample(gen_cos(ph), gen_sin(ph), lat, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dds%0d_s%0d_done got timeout", f, i); end
        d = pword - 16'(ph);
        checks++;
        if (d > 8 || d < -8) begin
          errors++;
          $display("FAIL dds%0d_s%0d_pword got %h want %h +-8", f, i, pword, 16'(ph));
        end
        if (i > 0) begin
          d = fword - ef;
          checks++;
          if (d > 16 || d < -16) begin
            errors++;
            $display("FAIL dds%0d_s%0d_fword got %h want %h +-16", f, i, fword, ef);
          end
        end
      end
    end
  endtask

  task automatic test_wrap;
    int lat;
    bit ok;
    logic signed [15:0] d;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_sample(gen_cos(32'hF000), gen_sin(32'hF000), lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_first_done got timeout"); end
    d = pword - 16'hF000;
    checks++;
    if (d > 8 || d < -8) begin errors++; $display("FAIL wrap_first_pword got %h want F000 +-8", pword); end
    checks++;
    if (fword !== 16'h0000) begin errors++; $display("FAIL wrap_first_fword got %h want 0000", fword); end
    send_sample(gen_cos(32'h1000), gen_sin(32'h1000), lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_second_done got timeout"); end
    d = fword - 16'h2000;
    checks++;
    if (d > 16 || d < -16) begin errors++; $display("FAIL wrap_second_fword got %h want 2000 +-16", fword); end
  endtask

  task automatic test_handshake;
    int acc [$];
    int ovc [$];
    bit rdy_hist [64];
    bit rdy;
    int low;
    logic signed [15:0] d;
    @(negedge clk);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      rdy = in_ready;
      rdy_hist[cyc] = rdy;
      if (rdy) begin
        cos_i = 14'd8192;
        sin_i = 14'd12192;
      end else begin
        // Anything driven while not ready must be ignored.
        cos_i = 14'($urandom_range(16383, 0));
        sin_i = 14'($urandom_range(16383, 0));
      end
      @(posedge clk);
      if (rdy) acc.push_back(cyc);
      #1;
      if (out_valid) begin
        ovc.push_back(cyc);
        d = pword - 16'd16384;
        checks++;
        if (d > 8 || d < -8) begin
          errors++;
          $display("FAIL hs_pword_c%0d got %0d want 16384 +-8", cyc, pword);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (acc.size() != 4) begin errors++; $display("FAIL hs_accepts got %0d want 4", acc.size()); end
    checks++;
    if (ovc.size() != 3) begin errors++; $display("FAIL hs_pulses got %0d want 3", ovc.size()); end
    if (acc.size() >= 2) begin
      checks++;
      if (acc[1] - acc[0] != 16) begin
        errors++;
        $display("FAIL hs_accept_period got %0d want 16", acc[1] - acc[0]);
      end
      low = 0;
      for (int c = acc[0] + 1; c < acc[1]; c++) if (!rdy_hist[c]) low++;
      checks++;
      if (low != 15) begin errors++; $display("FAIL hs_ready_low got %0d want 15", low); end
    end
    for (int i = 0; i < ovc.size() && i < acc.size(); i++) begin
      checks++;
      if (ovc[i] != acc[i] + 16) begin
        errors++;
        $display("FAIL hs_pulse%0d_cycle got %0d want %0d", i, ovc[i], acc[i] + 16);
      end
    end
    // Let the last in-flight sample finish and the FSM settle in IDLE.
    repeat (20) @(posedge clk);
  endtask

  task automatic test_midop_reset;
    int lat;
    bit ok;
    int pulses;
    logic signed [15:0] d;
    send_sample(14'd8192, 14'd12192, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mr_pre_done got timeout"); end
    @(negedge clk);
    cos_i    = 14'd12192;
    sin_i    = 14'd8192;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_idle_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got %b want 0", out_valid); end
    checks++;
    if (pword !== 16'h0000) begin errors++; $display("FAIL mr_pword got %h want 0000", pword); end
    checks++;
    if (fword !== 16'h0000) begin errors++; $display("FAIL mr_fword got %h want 0000", fword); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL mr_discard got %0d pulses want 0", pulses); end
    send_sample(14'd4192, 14'd8192, lat, ok);
    checks++;
    if (!ok || lat != 16) begin errors++; $display("FAIL mr_next_latency got %0d want 16", lat); end
    checks++;
    if (fword !== 16'h0000) begin errors++; $display("FAIL mr_next_fword got %h want 0000", fword); end
    d = pword - 16'd32768;
    checks++;
    if (d > 8 || d < -8) begin errors++; $display("FAIL mr_next_pword got %0d want 32768 +-8", pword); end
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_zero();
    test_dds_track();
    test_wrap();
    test_handshake();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_phase_detector.md
# dds_phase_detector

Recovers the instantaneous phase and the per-sample phase increment from a cos/sin sample pair in the same number formats that `dds` produces and consumes. It is the demodulating end of the DDS path: `dds` turns `pword`/`fword` into cos/sin, and this block turns cos/sin back into `pword`/`fword`. It sits downstream of a `dds` instance or an ADC I/Q front end, and it is used to close phase-modulation loops and to self-check the DDS. The core is an iterative CORDIC in vectoring mode behind a valid/ready input handshake.

## Interface
- `DEPTH_BITWIDTH`, 16, phase word width; one full turn equals 2^DEPTH_BITWIDTH.
- `DATA_BITWIDTH`, 14, width of the cos/sin inputs.
- `ITERATIONS`, 14, number of CORDIC micro-rotations; legal range is 4 to DEPTH_BITWIDTH-2.
- `clk`  in  1  the block's only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a sample is presented on `cos`/`sin`.
- `in_ready`  out  1  the block can accept a sample.
- `cos`  in  DATA_BITWIDTH  offset-binary; 2^(DATA_BITWIDTH-1) represents zero.
- `sin`  in  DATA_BITWIDTH  offset-binary; same zero point as `cos`.
- `out_valid`  out  1  one-cycle pulse; `pword`/`fword` are updated in this cycle.
- `pword`  out  DEPTH_BITWIDTH  recovered phase; 0 corresponds to (cos max, sin zero) and 2^(D-2) to (cos zero, sin max).
- `fword`  out  DEPTH_BITWIDTH  phase change since the previous result, modulo 2^D.

## Operation
- The FSM has four states: IDLE, PRE, ITER and DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid` is high, the block captures `cos`/`sin` and goes to PRE.
- PRE (1 cycle):
  - Convert each input to signed by subtracting 2^(DATA_BITWIDTH-1).
  - Sign-extend to DATA_BITWIDTH+2 bits. This gives headroom for the CORDIC gain of about 1.647.
  - If x<0: x=-x, y=-y, z=2^(D-1). Otherwise z=0.
  - If x==0 and y==0, set the zero flag.
  - Clear the iteration counter k and go to ITER.
- ITER (ITERATIONS cycles, k=0..ITERATIONS-1):
  - If y>=0: x+=y>>>k, y-=x>>>k, z+=A[k].
  - Otherwise: x-=y>>>k, y+=x>>>k, z-=A[k].
  - The right-hand sides use the old x and y.
  - A[k]=round(atan(2^-k)·2^D/(2π)) is a constant table computed at elaboration; for D=16, A[0]=8192 and A[1]=4836.
  - z is D bits and wraps modulo 2^D.
  - After k=ITERATIONS-1, go to DONE.
- DONE (1 cycle):
  - `pword` = z, or 0 if the zero flag is set.
  - `fword` = new `pword` minus the previous `pword`, modulo 2^D.
  - On the first result after reset, `fword`=0 and the first-flag is cleared.
  - `out_valid`=1 and `in_ready`=1. A sample accepted in this cycle goes directly to PRE.
  - If no sample is accepted, go to IDLE.
- Outputs hold their values between `out_valid` pulses.
- `in_valid` is ignored whenever `in_ready`=0. Nothing is queued.
- Accuracy requirement: for input magnitude ≥ 2^(DATA_BITWIDTH-3), |`pword` error| ≤ 8 LSB and |`fword` error| ≤ 16 LSB.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `pword`=0, `fword`=0, FSM in IDLE, first-flag set.
- Accept edge T is the edge where `in_valid` & `in_ready`.
  - PRE is the cycle after T.
  - ITER occupies the next ITERATIONS cycles.
  - `out_valid` is high during the cycle that starts at edge T+ITERATIONS+2.
- Latency and throughput: ITERATIONS+2 cycles, which is 16 with defaults.
- `in_ready` is 0 from edge T+1 until DONE. Maximum accept rate is one sample per ITERATIONS+2 cycles.
- Reset asserted mid-operation:
  - All state returns to reset values immediately, asynchronously.
  - The in-flight sample is discarded and no `out_valid` is produced for it.
  - The next result after reset has `fword`=0.
- Phase wrap: z crossing 2^D−1→0 wraps silently. `fword` uses modular subtraction, so 0xF000→0x1000 yields 0x2000.

## Test plan
- Quadrant points, D=16, DW=14:
  - (cos,sin)=(12192,8192) → `pword`≈0.
  - (8192,12192) → `pword`≈16384.
  - (4192,8192) → `pword`≈32768.
  - (8192,4192) → `pword`≈49152.
  - Each within ±8 LSB, with `out_valid` exactly 16 cycles after the accept edge.
- Drive from `dds` with `fword`=0x1000 and `pword`=0, and feed every 16th output sample. Required: `fword` out ≈ 16·0x1000 mod 2^16 = 0 ±16 LSB. Repeat with a DDS `fword`=0x0100, which must give `fword` out ≈ 0x1000 ±16.
- Wrap: feed phases 0xF000 then 0x1000 → second result `fword`≈0x2000 ±16. The first result after reset must have `fword`=0.
- Handshake: hold `in_valid`=1 continuously.
  - One accept every 16 cycles.
  - `in_ready` low for 15 cycles between accepts.
  - `out_valid` is a single-cycle pulse.
  - Samples changed while `in_ready`=0 must not affect results.
- Zero input (8192,8192) → `pword`=0.
- Reset: assert `rst` at ITER k=5 → no `out_valid` for that sample, outputs read 0 and `in_ready`=1 immediately, and the next result has `fword`=0.
